// File: rtl/mdu_pkg.sv
// ----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the MDU divider slice. It holds:
//   - state_t    : divider sequencer states (IDLE, CALC, FIX)
//   - WIDTH      : default operand/result width
//   - DIV0_QUOT  : raw quotient produced by a divide by zero (all ones)
// No ports (package).
// ----------------------------------------------------------------------------
package mdu_pkg;

    localparam int WIDTH = 32;

    localparam logic [WIDTH-1:0] DIV0_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/mdu_divider_div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One combinational radix-2 restoring division iteration.
//   rem      in  WIDTH  partial remainder (always < divisor when divisor != 0)
//   quo      in  WIDTH  remaining dividend bits (MSB first); quotient bits
//                       enter at the LSB
//   divisor  in  WIDTH  divisor magnitude
//   next_rem out WIDTH  partial remainder after this iteration
//   next_quo out WIDTH  quo shifted left with the new quotient bit appended
// ----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quo
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor keeps shifted < 2*divisor, so the trial difference always
    // fits in WIDTH+1 bits and its MSB is a reliable sign. With a zero divisor
    // the remainder only ever holds leading dividend bits, so the MSB stays 0.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign trial    = shifted - {1'b0, divisor};
    assign next_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign next_quo = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/mdu_divider.sv
// ----------------------------------------------------------------------------
// mdu_divider
// Sequential radix-2 restoring divider for MIPS-style DIV/DIVU. One quotient
// bit per clock; results land on hi (remainder) and lo (quotient).
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   request, sampled only in IDLE (not in the done cycle)
//   is_signed    in   1 = DIV (two's complement), 0 = DIVU
//   a            in   WIDTH  dividend
//   b            in   WIDTH  divisor
//   busy         out  high from the cycle after acceptance until done
//   done         out  one-cycle pulse, hi/lo valid from this cycle on
//   hi           out  WIDTH  remainder (sign follows the dividend)
//   lo           out  WIDTH  quotient (truncated toward zero)
//   div_by_zero  out  set with done when b == 0, held until next accepted start
// Optional build macro MDU_DIV_EARLY_OUT_EN: when defined, b == 0 or
// |a| < |b| skips the iteration phase and finishes in two cycles.
// ----------------------------------------------------------------------------
module mdu_divider #(
    parameter  int WIDTH = mdu_pkg::WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    import mdu_pkg::*;

    localparam logic [WIDTH-1:0] QUOT_ONES = {WIDTH{DIV0_QUOT[0]}};

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x,
                                                    input logic             neg);
        return neg ? -x : x;
    endfunction

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sgn;
    logic             q_neg;
    logic             r_neg;
    logic             b_zero;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] next_quo;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign a_mag = magnitude(a, is_signed);
    assign b_mag = magnitude(b, is_signed);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .next_rem (next_rem),
        .next_quo (next_quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            sgn         <= 1'b0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            b_zero      <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            divisor     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // The done cycle still sits in IDLE but closes the
                    // previous operation, so a start there is not taken.
                    if (start && !done) begin
                        sgn         <= is_signed;
                        q_neg       <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_neg       <= a[WIDTH-1];
                        b_zero      <= (b == '0);
                        divisor     <= b_mag;
                        cnt         <= CNT_W'(WIDTH - 1);
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
`ifdef MDU_DIV_EARLY_OUT_EN
                        if ((b == '0) || (a_mag < b_mag)) begin
                            // Quotient is 0 (or overridden for b == 0) and
                            // the whole dividend is the remainder.
                            rem   <= a_mag;
                            quo   <= '0;
                            state <= FIX;
                        end else begin
                            rem   <= '0;
                            quo   <= a_mag;
                            state <= CALC;
                        end
`else
                        rem   <= '0;
                        quo   <= a_mag;
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    rem <= next_rem;
                    quo <= next_quo;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    // A zero divisor leaves the raw all-ones quotient; the
                    // remainder path naturally reproduces the dividend.
                    lo          <= b_zero ? QUOT_ONES : apply_sign(quo, q_neg & sgn);
                    hi          <= apply_sign(rem, r_neg & sgn);
                    div_by_zero <= b_zero;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_divider.sv
// ----------------------------------------------------------------------------
// tb_mdu_divider
// Self-checking bench for mdu_divider. Expected results are pushed into a
// scoreboard queue when an operation is launched and compared when done
// pulses. Latency expectations follow MDU_DIV_EARLY_OUT_EN when defined.
// ----------------------------------------------------------------------------
module tb_mdu_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    typedef struct packed {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    mdu_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t         e;
        logic [W-1:0] mx;
        logic [W-1:0] my;
        e.dbz = (y == '0);
        if (y == '0) begin
            e.lo = '1;
            e.hi = x;
        end else if (!s) begin
            e.lo = x / y;
            e.hi = x % y;
        end else begin
            mx   = x[W-1] ? -x : x;
            my   = y[W-1] ? -y : y;
            e.lo = mx / my;
            e.hi = mx % my;
            if (x[W-1] ^ y[W-1]) e.lo = -e.lo;
            if (x[W-1]) e.hi = -e.hi;
        end
        return e;
    endfunction

    function automatic int exp_latency(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int lat;
        lat = W + 2;
`ifdef MDU_DIV_EARLY_OUT_EN
        begin
            logic [W-1:0] mx;
            logic [W-1:0] my;
            mx = (s && x[W-1]) ? -x : x;
            my = (s && y[W-1]) ? -y : y;
            if ((y == '0) || (mx < my)) lat = 2;
        end
`endif
        return lat;
    endfunction

    // Scoreboard monitor: compare on every done pulse, away from the edge.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", W'(1), W'(0));
            end else begin
                mon_e = sb.pop_front();
                chk("lo", lo, mon_e.lo);
                chk("hi", hi, mon_e.hi);
                chk("div_by_zero", W'(div_by_zero), W'(mon_e.dbz));
                chk("busy_at_done", W'(busy), W'(0));
            end
        end
    end

    // Launch one operation and wait for its done pulse. inj1/inj2 pulse a
    // junk start at those cycle counts; inj_done pulses one in the done cycle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                          input int inj1, input int inj2, input bit inj_done);
        int           cnt;
        int           lat;
        logic [W-1:0] prev_lo;
        @(negedge clk);
        prev_lo   = lo;
        a         = ta;
        b         = tb_v;
        is_signed = ts;
        start     = 1'b1;
        sb.push_back(model(ta, tb_v, ts));
        lat = exp_latency(ta, tb_v, ts);
        cnt = 0;
        while (cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) chk("busy_after_start", W'(busy), W'(1));
            if (cnt == 3 && lat > 3) chk("lo_hold_in_calc", lo, prev_lo);
            if (done) begin
                start = inj_done;
                if (inj_done) begin
                    a = $urandom;
                    b = $urandom;
                    is_signed = 1'($urandom);
                end
                break;
            end
            start = (cnt == inj1) || (cnt == inj2);
            if (start) begin
                a = $urandom;
                b = $urandom;
                is_signed = 1'($urandom);
            end
        end
        chk("latency", W'(cnt), W'(lat));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_hi", hi, W'(0));
        chk("rst_lo", lo, W'(0));
        chk("rst_dbz", W'(div_by_zero), W'(0));
        rst_n = 1'b1;

        run_op(32'd100, 32'd7, 1'b0, -1, -1, 1'b0);
        run_op(32'hFFFF_FF9C, 32'd7, 1'b1, -1, -1, 1'b0);
        run_op(32'd100, 32'hFFFF_FFF9, 1'b1, -1, -1, 1'b0);
        run_op(32'h1234_5678, 32'd0, 1'b0, -1, -1, 1'b0);
        run_op(32'hF000_0000, 32'd0, 1'b1, -1, -1, 1'b0);
        run_op(32'd5, 32'd1, 1'b0, -1, -1, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, -1, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, -1, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, -1, -1, 1'b0);
        run_op(32'd3, 32'd10, 1'b0, -1, -1, 1'b0);
        run_op(32'hFFFF_FFFD, 32'd10, 1'b1, -1, -1, 1'b0);

        // Junk starts mid-op, in FIX and in the done cycle; then back-to-back.
        run_op(32'd1000, 32'd33, 1'b0, 5, 33, 1'b1);
        run_op(32'd77, 32'd7, 1'b0, -1, -1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_op(ra, rb, 1'($urandom), -1, -1, 1'b0);
        end

        // Reset in the middle of an operation discards it immediately.
        @(negedge clk);
        a         = 32'd100;
        b         = 32'd7;
        is_signed = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", W'(busy), W'(0));
        chk("midrst_done", W'(done), W'(0));
        chk("midrst_hi", hi, W'(0));
        chk("midrst_lo", lo, W'(0));
        chk("midrst_dbz", W'(div_by_zero), W'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd9, 32'd3, 1'b0, -1, -1, 1'b0);

        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("scoreboard_drained", W'(sb.size()), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
